// File: rtl/fpmult_pipe.sv
// fpmult_pipe: fully pipelined floating-point multiplier with parametrised field widths,
// round-to-nearest-even, flush-to-zero, exception flags and valid/ready backpressure.
module fpmult_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] dataa,
    input  logic [EXP_W+MAN_W:0] datab,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * (MAN_W + 1);
    localparam logic signed [EW-1:0] BIAS = EW'((2 ** (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX = EW'((2 ** EXP_W) - 1);

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    function automatic logic [MAN_W:0] rne_round(input logic [MAN_W-1:0] frac,
                                                 input logic grd, input logic stk);
        logic up;
        up = grd && (stk || frac[0]);
        return {1'b0, frac} + {{MAN_W{1'b0}}, up};
    endfunction

    // Returns {flags, result}: saturate to inf on overflow, flush to zero on underflow.
    function automatic logic [W+3:0] pack_finite(input logic sign,
                                                 input logic signed [EW-1:0] ex,
                                                 input logic [MAN_W:0] rnd,
                                                 input logic inexact);
        logic signed [EW-1:0] e;
        e = ex + $signed({{(EW-1){1'b0}}, rnd[MAN_W]});
        if (e >= EMAX)
            return {4'b0101, sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (e[EW-1] || e == '0)
            return {4'b0011, sign, {(EXP_W+MAN_W){1'b0}}};
        else
            return {3'b000, inexact, sign, e[EXP_W-1:0], rnd[MAN_W-1:0]};
    endfunction

    logic                 vld_p0, vld_p1, vld_p2;
    logic [W-1:0]         a_p0, b_p0;
    logic                 sign_p1, nan_p1, inf_p1, zero_p1;
    logic signed [EW-1:0] exp_p1;
    logic [PW-1:0]        prod_p1;
    logic                 sign_p2, nan_p2, inf_p2, zero_p2, grd_p2, stk_p2;
    logic signed [EW-1:0] exp_p2;
    logic [MAN_W-1:0]     frac_p2;

    // ---- stage 1: unpack, classify, exponent sum, mantissa product ----
    logic [EXP_W-1:0]     ea, eb;
    logic [MAN_W-1:0]     fa, fb;
    logic                 za, zb, ia, ib, na, nb;
    logic                 nan_s1, inf_s1, zero_s1;
    logic signed [EW-1:0] exp_s1;
    logic [PW-1:0]        prod_s1;

    assign ea      = a_p0[W-2 -: EXP_W];
    assign eb      = b_p0[W-2 -: EXP_W];
    assign fa      = a_p0[MAN_W-1:0];
    assign fb      = b_p0[MAN_W-1:0];
    assign za      = (ea == '0);
    assign zb      = (eb == '0);
    assign ia      = (ea == '1) && (fa == '0);
    assign ib      = (eb == '1) && (fb == '0);
    assign na      = (ea == '1) && (fa != '0);
    assign nb      = (eb == '1) && (fb != '0);
    assign nan_s1  = na || nb || (ia && zb) || (ib && za);
    assign inf_s1  = !nan_s1 && (ia || ib);
    assign zero_s1 = !nan_s1 && !inf_s1 && (za || zb);
    assign exp_s1  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
    assign prod_s1 = PW'({1'b1, fa}) * PW'({1'b1, fb});

    // ---- stage 2: normalise product from [1,4) to [1,2), extract guard/sticky ----
    logic [PW-2:0]        norm_s2;
    logic signed [EW-1:0] exp_s2;

    assign norm_s2 = prod_p1[PW-1] ? prod_p1[PW-2:0] : {prod_p1[PW-3:0], 1'b0};
    assign exp_s2  = exp_p1 + $signed({{(EW-1){1'b0}}, prod_p1[PW-1]});

    // ---- stage 3: round, range check, special-case override ----
    logic [MAN_W:0] rnd_s3;
    logic [W+3:0]   pack_s3;

    always_comb begin
        rnd_s3 = rne_round(frac_p2, grd_p2, stk_p2);
        if (nan_p2)
            pack_s3 = {4'b1000, 1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        else if (inf_p2)
            pack_s3 = {4'b0000, sign_p2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (zero_p2)
            pack_s3 = {4'b0000, sign_p2, {(EXP_W+MAN_W){1'b0}}};
        else
            pack_s3 = pack_finite(sign_p2, exp_p2, rnd_s3, grd_p2 || stk_p2);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (en) begin
            vld_p0    <= in_valid;
            vld_p1    <= vld_p0;
            vld_p2    <= vld_p1;
            out_valid <= vld_p2;
            result    <= pack_s3[W-1:0];
            flags     <= pack_s3[W+3:W];
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            a_p0    <= dataa;
            b_p0    <= datab;
            sign_p1 <= a_p0[W-1] ^ b_p0[W-1];
            nan_p1  <= nan_s1;
            inf_p1  <= inf_s1;
            zero_p1 <= zero_s1;
            exp_p1  <= exp_s1;
            prod_p1 <= prod_s1;
            sign_p2 <= sign_p1;
            nan_p2  <= nan_p1;
            inf_p2  <= inf_p1;
            zero_p2 <= zero_p1;
            exp_p2  <= exp_s2;
            frac_p2 <= norm_s2[PW-2 -: MAN_W];
            grd_p2  <= norm_s2[PW-2-MAN_W];
            stk_p2  <= |norm_s2[PW-3-MAN_W:0];
        end
    end

endmodule

// File: tb/tb_fpmult_pipe.sv
// Bench for fpmult_pipe: directed vectors, randomized stream against an arithmetic
// reference model, backpressure, mid-stream reset and a half-precision instance.
module tb_fpmult_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] dataa, datab, result;
    logic [3:0]  flags;
    logic        in_valid_h, in_ready_h, out_valid_h, out_ready_h;
    logic [15:0] dataa_h, datab_h, result_h;
    logic [3:0]  flags_h;

    int passed = 0;
    int total  = 0;

    fpmult_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .dataa(dataa), .datab(datab), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    fpmult_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .reset(reset), .in_valid(in_valid_h), .in_ready(in_ready_h),
        .dataa(dataa_h), .datab(datab_h), .out_valid(out_valid_h), .out_ready(out_ready_h),
        .result(result_h), .flags(flags_h)
    );

    // Reference: exact integer product, rounded by comparing the discarded remainder with one half.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
        logic s, anan, bnan, ainf, binf, az, bz, inexact;
        int ea, eb, e, sh;
        longint unsigned p, q, rem, half, one;
        s    = a[31] ^ b[31];
        ea   = int'(a[30:23]);
        eb   = int'(b[30:23]);
        anan = (ea == 255) && (a[22:0] != 0);
        bnan = (eb == 255) && (b[22:0] != 0);
        ainf = (ea == 255) && (a[22:0] == 0);
        binf = (eb == 255) && (b[22:0] == 0);
        az   = (ea == 0);
        bz   = (eb == 0);
        if (anan || bnan || (ainf && bz) || (binf && az)) return {4'b1000, 32'h7fc00000};
        if (ainf || binf) return {4'b0000, s, 8'hff, 23'h0};
        if (az || bz) return {4'b0000, s, 31'h0};
        one = 64'd1;
        p   = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
        e   = ea + eb - 127;
        sh  = (p >= (one << 47)) ? 24 : 23;
        if (sh == 24) e++;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = one << (sh - 1);
        inexact = (rem != 0);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == (one << 24)) begin
            q = q >> 1;
            e++;
        end
        if (e >= 255) return {4'b0101, s, 8'hff, 23'h0};
        if (e <= 0) return {4'b0011, s, 31'h0};
        return {3'b000, inexact, s, 8'(e), q[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        int k;
        v = $urandom;
        k = $urandom_range(0, 15);
        if (k == 0) v[30:23] = 8'h00;
        else if (k == 1) v[30:0] = {8'hff, 23'h0};
        else if (k == 2) v[30:23] = 8'hff;
        else if (k == 3 || k == 4) v = v;
        else if (k == 5) begin
            v[30:23] = 8'($urandom_range(110, 140));
            v[22:0]  = 23'($urandom_range(0, 7));
        end else v[30:23] = 8'($urandom_range(96, 158));
        return v;
    endfunction

    task automatic test_reset;
        reset = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b0;
        dataa = 32'h3f800000;
        datab = 32'h40000000;
        repeat (3) @(negedge clk);
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (result !== 32'h0) $display("FAIL reset_result: got %h want 00000000", result); else passed++;
        total++; if (flags !== 4'h0) $display("FAIL reset_flags: got %b want 0000", flags); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        reset = 1'b1;
    endtask

    task automatic test_directed;
        logic [31:0] va [7] = '{32'h3fc00000, 32'h7f000000, 32'h00800000, 32'h7f800000,
                                32'h7fc00001, 32'hff800000, 32'h3f800001};
        logic [31:0] vb [7] = '{32'hbfc00000, 32'h40000000, 32'h00800000, 32'h00000000,
                                32'h3f800000, 32'h40000000, 32'h3f800001};
        logic [31:0] vr [7] = '{32'hc0100000, 32'h7f800000, 32'h00000000, 32'h7fc00000,
                                32'h7fc00000, 32'hff800000, 32'h3f800002};
        logic [3:0]  vf [7] = '{4'b0000, 4'b0101, 4'b0011, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
        for (int i = 0; i < 7; i++) begin
            int lat;
            @(negedge clk);
            dataa = va[i];
            datab = vb[i];
            in_valid = 1'b1;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat = 0;
            while (!out_valid && lat < 10) begin
                @(posedge clk);
                #1;
                lat++;
            end
            total++;
            if ({out_valid, flags, result} !== {1'b1, vf[i], vr[i]})
                $display("FAIL directed[%0d]: got valid=%b result=%h flags=%b, want valid=1 result=%h flags=%b",
                         i, out_valid, result, flags, vr[i], vf[i]);
            else passed++;
            if (i == 0) begin
                total++; if (lat !== 3) $display("FAIL latency: got %0d want 3", lat); else passed++;
            end
            @(posedge clk);
        end
    endtask

    task automatic test_random;
        logic [35:0] expq [$];
        logic [35:0] ex;
        int issued = 0;
        int cyc = 0;
        while ((issued < 300 || expq.size() > 0) && cyc < 4000) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0) || (issued >= 300);
            in_valid  = (issued < 300) && ($urandom_range(0, 3) != 0);
            dataa = rand_op();
            datab = rand_op();
            #1;
            if (out_valid && out_ready) begin
                total++;
                if (expq.size() == 0) $display("FAIL random_extra: got result=%h with nothing outstanding", result);
                else begin
                    ex = expq.pop_front();
                    if ({flags, result} !== ex)
                        $display("FAIL random: got result=%h flags=%b want result=%h flags=%b",
                                 result, flags, ex[31:0], ex[35:32]);
                    else passed++;
                end
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(dataa, datab));
                issued++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        total++;
        if (issued != 300 || expq.size() != 0)
            $display("FAIL random_drain: issued %0d outstanding %0d, want 300 and 0", issued, expq.size());
        else passed++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] va [4] = '{32'h3fc00000, 32'h40400000, 32'h3f800001, 32'h7f000000};
        logic [31:0] vb [4] = '{32'h40000000, 32'hc0a00000, 32'h3f800001, 32'h40000000};
        logic [35:0] ex [4];
        int sent = 0;
        int got = 0;
        int stall = 0;
        int extra = 0;
        logic taken_first = 1'b0;
        for (int i = 0; i < 4; i++) ex[i] = model(va[i], vb[i]);
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clk);
            out_ready = !(taken_first && stall < 2);
            in_valid  = (sent < 4);
            if (sent < 4) begin
                dataa = va[sent];
                datab = vb[sent];
            end
            #1;
            if (!out_ready) begin
                total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b want 0", in_ready); else passed++;
                total++;
                if ({out_valid, flags, result} !== {1'b1, ex[got]})
                    $display("FAIL stall_hold: got valid=%b result=%h flags=%b want valid=1 result=%h flags=%b",
                             out_valid, result, flags, ex[got][31:0], ex[got][35:32]);
                else passed++;
                stall++;
            end
            if (out_valid && out_ready) begin
                total++;
                if ({flags, result} !== ex[got])
                    $display("FAIL b2b[%0d]: got result=%h flags=%b want result=%h flags=%b",
                             got, result, flags, ex[got][31:0], ex[got][35:32]);
                else passed++;
                got++;
                taken_first = 1'b1;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        total++; if (got != 4) $display("FAIL b2b_count: got %0d results want 4", got); else passed++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        total++; if (extra != 0) $display("FAIL b2b_duplicate: got %0d extra results want 0", extra); else passed++;
    endtask

    task automatic test_reset_midstream;
        int stale = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            dataa = rand_op();
            datab = rand_op();
        end
        #1;
        total++; if (out_valid !== 1'b1) $display("FAIL midreset_prefill: got valid=%b want 1", out_valid); else passed++;
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        total++;
        if ({out_valid, flags, result} !== 37'h0)
            $display("FAIL midreset_clear: got valid=%b result=%h flags=%b want all 0", out_valid, result, flags);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        total++; if (stale != 0) $display("FAIL midreset_stale: got %0d stale results want 0", stale); else passed++;
    endtask

    task automatic test_half;
        logic [15:0] va [2] = '{16'h3e00, 16'h7bff};
        logic [15:0] vb [2] = '{16'hbe00, 16'h4000};
        logic [15:0] vr [2] = '{16'hc080, 16'h7c00};
        logic [3:0]  vf [2] = '{4'b0000, 4'b0101};
        for (int i = 0; i < 2; i++) begin
            int lat;
            @(negedge clk);
            dataa_h = va[i];
            datab_h = vb[i];
            in_valid_h = 1'b1;
            out_ready_h = 1'b1;
            @(posedge clk);
            #1;
            in_valid_h = 1'b0;
            lat = 0;
            while (!out_valid_h && lat < 10) begin
                @(posedge clk);
                #1;
                lat++;
            end
            total++;
            if ({out_valid_h, flags_h, result_h} !== {1'b1, vf[i], vr[i]})
                $display("FAIL half[%0d]: got valid=%b result=%h flags=%b want valid=1 result=%h flags=%b",
                         i, out_valid_h, result_h, flags_h, vr[i], vf[i]);
            else passed++;
            if (i == 0) begin
                total++; if (lat !== 3) $display("FAIL half_latency: got %0d want 3", lat); else passed++;
            end
            @(posedge clk);
        end
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        dataa = '0;
        datab = '0;
        in_valid_h = 1'b0;
        out_ready_h = 1'b1;
        dataa_h = '0;
        datab_h = '0;
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_reset_midstream;
        test_half;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
